// File: rtl/spi_flash_responder_if.sv
// SPI flash link bundle: master drives sck/cs/mosi, the responder drives
// miso plus its status and debug outputs.
interface spi_flash_responder_if;
    logic       sck;
    logic       cs;
    logic       mosi;
    logic       miso;
    logic       wel;
    logic       wip;
    logic [3:0] state_out;

    modport master (
        output sck, cs, mosi,
        input  miso, wel, wip, state_out
    );

    modport slave (
        input  sck, cs, mosi,
        output miso, wel, wip, state_out
    );
endinterface

// File: rtl/spi_flash_responder.sv
// Oversampled SPI NOR-flash responder (mode 0, MSB first) backed by a byte array.
//   state  | meaning
//   IDLE   | cs high, link idle
//   OPCODE | shifting in the 8 opcode bits
//   ADDR   | shifting in 24 address bits for READ or PP
//   READ   | streaming array bytes out on miso
//   PROG   | AND-programming received bytes into the current page
//   RDSR   | streaming the status byte
//   IGNORE | command rejected or complete; waiting for cs to rise
module spi_flash_responder #(
    parameter int MEM_ADDR_BITS = 8,
    parameter int PROG_CYCLES   = 64,
    parameter int ERASE_CYCLES  = 1024
) (
    input  logic                  i_main_clock,
    input  logic                  i_rst_n,
    spi_flash_responder_if.slave  spi
);
    localparam int DEPTH     = 1 << MEM_ADDR_BITS;
    localparam int MAX_CYC   = (ERASE_CYCLES > PROG_CYCLES) ? ERASE_CYCLES : PROG_CYCLES;
    localparam int CNT_W     = $clog2(MAX_CYC + 1);
    localparam int PAGE_BITS = (MEM_ADDR_BITS < 8) ? MEM_ADDR_BITS : 8;
    localparam logic [MEM_ADDR_BITS-1:0] PAGE_MASK =
        MEM_ADDR_BITS'((64'd1 << PAGE_BITS) - 64'd1);

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_OPCODE = 4'd1;
    localparam logic [3:0] ST_ADDR   = 4'd2;
    localparam logic [3:0] ST_READ   = 4'd3;
    localparam logic [3:0] ST_PROG   = 4'd4;
    localparam logic [3:0] ST_RDSR   = 4'd5;
    localparam logic [3:0] ST_IGNORE = 4'd6;

    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_CE   = 8'hC7;

    localparam logic [1:0] PEND_NONE = 2'd0;
    localparam logic [1:0] PEND_WREN = 2'd1;
    localparam logic [1:0] PEND_WRDI = 2'd2;
    localparam logic [1:0] PEND_CE   = 2'd3;

    logic [1:0]               r_sck_s;
    logic [1:0]               r_cs_s;
    logic [1:0]               r_mosi_s;
    logic                     r_sck_q;
    logic                     r_cs_q;
    logic [3:0]               r_state;
    logic [4:0]               r_bit_cnt;
    logic [6:0]               r_shift;
    logic [MEM_ADDR_BITS-1:0] r_addr;
    logic                     r_is_pp;
    logic                     r_pp_done;
    logic [1:0]               r_pend;
    logic [7:0]               r_tx;
    logic [2:0]               r_tx_cnt;
    logic                     r_miso;
    logic                     r_wel;
    logic                     r_wip;
    logic [CNT_W-1:0]         r_wip_cnt;
    logic                     r_sweep;
    logic [MEM_ADDR_BITS-1:0] r_sweep_addr;
    // Stored inverted so the all-zero power-up state of the flops reads as erased 8'hFF.
    logic [7:0]               r_mem_n [DEPTH];

    logic                     w_sck;
    logic                     w_cs;
    logic                     w_mosi;
    logic                     w_sck_rise;
    logic                     w_sck_fall;
    logic                     w_cs_rise;
    logic                     w_cs_fall;
    logic [7:0]               w_byte;
    logic [7:0]               w_status;
    logic [7:0]               w_tx_byte;
    logic [MEM_ADDR_BITS-1:0] w_addr_inc;
    logic [MEM_ADDR_BITS-1:0] w_pp_next;
    logic                     w_prog_we;

    assign w_sck      = r_sck_s[1];
    assign w_cs       = r_cs_s[1];
    assign w_mosi     = r_mosi_s[1];
    assign w_sck_rise = w_sck & ~r_sck_q;
    assign w_sck_fall = ~w_sck & r_sck_q;
    assign w_cs_rise  = w_cs & ~r_cs_q;
    assign w_cs_fall  = ~w_cs & r_cs_q;
    assign w_byte     = {r_shift, w_mosi};
    assign w_status   = {6'b0, r_wel, r_wip};
    assign w_tx_byte  = (r_state == ST_RDSR) ? w_status : ~r_mem_n[r_addr];
    assign w_addr_inc = r_addr + MEM_ADDR_BITS'(1);
    assign w_pp_next  = (r_addr & ~PAGE_MASK) | (w_addr_inc & PAGE_MASK);
    assign w_prog_we  = ~w_cs & ~r_cs_q & w_sck_rise & (r_state == ST_PROG)
                      & (r_bit_cnt[2:0] == 3'd7);

    assign spi.miso      = r_miso;
    assign spi.wel       = r_wel;
    assign spi.wip       = r_wip;
    assign spi.state_out = r_state;

    always_ff @(posedge i_main_clock) begin
        if (i_rst_n) begin
            if (r_sweep) begin
                r_mem_n[r_sweep_addr] <= 8'h00;
            end else if (w_prog_we) begin
                r_mem_n[r_addr] <= r_mem_n[r_addr] | ~w_byte;
            end
        end
    end

    always_ff @(posedge i_main_clock) begin
        if (!i_rst_n) begin
            r_sck_s      <= 2'b00;
            r_cs_s       <= 2'b11;
            r_mosi_s     <= 2'b00;
            r_sck_q      <= 1'b0;
            r_cs_q       <= 1'b1;
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_addr       <= '0;
            r_is_pp      <= 1'b0;
            r_pp_done    <= 1'b0;
            r_pend       <= PEND_NONE;
            r_tx         <= '0;
            r_tx_cnt     <= '0;
            r_miso       <= 1'b0;
            r_wel        <= 1'b0;
            r_wip        <= 1'b0;
            r_wip_cnt    <= '0;
            r_sweep      <= 1'b0;
            r_sweep_addr <= '0;
        end else begin
            r_sck_s  <= {r_sck_s[0], spi.sck};
            r_cs_s   <= {r_cs_s[0], spi.cs};
            r_mosi_s <= {r_mosi_s[0], spi.mosi};
            r_sck_q  <= w_sck;
            r_cs_q   <= w_cs;

            if (r_wip) begin
                if (r_wip_cnt == '0) r_wip <= 1'b0;
                else                 r_wip_cnt <= r_wip_cnt - CNT_W'(1);
            end
            if (r_sweep) begin
                r_sweep_addr <= r_sweep_addr + MEM_ADDR_BITS'(1);
                if (&r_sweep_addr) r_sweep <= 1'b0;
            end

            // A cs rise outranks any sck edge seen in the same sample.
            if (w_cs) begin
                r_state   <= ST_IDLE;
                r_bit_cnt <= '0;
                r_tx_cnt  <= '0;
                r_miso    <= 1'b0;
                r_pend    <= PEND_NONE;
                r_pp_done <= 1'b0;
                if (w_cs_rise) begin
                    case (r_pend)
                        PEND_WREN: r_wel <= 1'b1;
                        PEND_WRDI: r_wel <= 1'b0;
                        PEND_CE: begin
                            r_wel        <= 1'b0;
                            r_wip        <= 1'b1;
                            r_wip_cnt    <= CNT_W'(ERASE_CYCLES - 1);
                            r_sweep      <= 1'b1;
                            r_sweep_addr <= '0;
                        end
                        default: ;
                    endcase
                    if (r_state == ST_PROG && r_pp_done) begin
                        r_wel     <= 1'b0;
                        r_wip     <= 1'b1;
                        r_wip_cnt <= CNT_W'(PROG_CYCLES - 1);
                    end
                end
            end else if (w_cs_fall) begin
                r_state   <= ST_OPCODE;
                r_bit_cnt <= '0;
                r_tx_cnt  <= '0;
                r_miso    <= 1'b0;
                r_pend    <= PEND_NONE;
                r_pp_done <= 1'b0;
            end else begin
                case (r_state)
                    ST_OPCODE: if (w_sck_rise) begin
                        r_shift <= w_byte[6:0];
                        if (r_bit_cnt == 5'd7) begin
                            r_bit_cnt <= '0;
                            r_state   <= ST_IGNORE;
                            case (w_byte)
                                OP_RDSR: r_state <= ST_RDSR;
                                OP_READ: if (!r_wip) begin
                                    r_state <= ST_ADDR;
                                    r_is_pp <= 1'b0;
                                end
                                OP_PP: if (!r_wip && r_wel) begin
                                    r_state <= ST_ADDR;
                                    r_is_pp <= 1'b1;
                                end
                                OP_WREN: if (!r_wip) r_pend <= PEND_WREN;
                                OP_WRDI: if (!r_wip) r_pend <= PEND_WRDI;
                                OP_CE:   if (!r_wip && r_wel) r_pend <= PEND_CE;
                                default: ;
                            endcase
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                    ST_ADDR: if (w_sck_rise) begin
                        r_addr <= {r_addr[MEM_ADDR_BITS-2:0], w_mosi};
                        if (r_bit_cnt == 5'd23) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_is_pp ? ST_PROG : ST_READ;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                    ST_PROG: if (w_sck_rise) begin
                        r_shift <= w_byte[6:0];
                        if (r_bit_cnt[2:0] == 3'd7) begin
                            r_bit_cnt <= '0;
                            r_addr    <= w_pp_next;
                            r_pp_done <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                    ST_READ, ST_RDSR: if (w_sck_fall) begin
                        r_tx_cnt <= r_tx_cnt + 3'd1;
                        if (r_tx_cnt == 3'd0) begin
                            r_miso <= w_tx_byte[7];
                            r_tx   <= {w_tx_byte[6:0], 1'b0};
                            if (r_state == ST_READ) r_addr <= w_addr_inc;
                        end else begin
                            r_miso <= r_tx[7];
                            r_tx   <= {r_tx[6:0], 1'b0};
                        end
                    end
                    ST_IGNORE: if (w_sck_rise) r_pend <= PEND_NONE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: a command table plus hand-built
// sequences for page wrap, partial bytes, chip erase, abort and reset.
module tb_spi_flash_responder;
    localparam int HALF      = 4;
    localparam int PROG_CYC  = 200;
    localparam int ERASE_CYC = 1024;

    localparam int K_CMD  = 0;
    localparam int K_RDSR = 1;
    localparam int K_READ = 2;
    localparam int K_PP   = 3;

    typedef struct {
        string      name;
        int         kind;
        logic [7:0] op;
        logic [23:0] addr;
        logic [7:0] data;
        logic [7:0] exp_rd;
        logic       exp_wel;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_flash_responder_if spi();

    spi_flash_responder #(
        .MEM_ADDR_BITS(8),
        .PROG_CYCLES  (PROG_CYC),
        .ERASE_CYCLES (ERASE_CYC)
    ) dut (
        .i_main_clock(clk),
        .i_rst_n     (rst_n),
        .spi         (spi)
    );

    int n_vec = 0;
    int n_err = 0;
    int wip_run = 0;
    int wip_last = 0;

    always @(posedge clk) begin
        if (spi.wip === 1'b1) wip_run++;
        else if (wip_run != 0) begin
            wip_last = wip_run;
            wip_run  = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got still running expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_lo();
        spi.cs = 1'b0;
        clk_wait(HALF);
    endtask

    task automatic cs_hi();
        clk_wait(HALF);
        spi.cs = 1'b1;
        clk_wait(2 * HALF);
    endtask

    task automatic xfer_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            spi.mosi = tx[7-i];
            clk_wait(HALF);
            rx = {rx[6:0], spi.miso};
            spi.sck = 1'b1;
            clk_wait(HALF);
            spi.sck = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        xfer_bits(tx, 8, rx);
    endtask

    task automatic send_addr(input logic [23:0] a);
        logic [7:0] d;
        xfer(a[23:16], d);
        xfer(a[15:8], d);
        xfer(a[7:0], d);
    endtask

    task automatic cmd(input logic [7:0] op);
        logic [7:0] d;
        cs_lo();
        xfer(op, d);
        cs_hi();
    endtask

    task automatic rdsr(output logic [7:0] s);
        logic [7:0] d;
        cs_lo();
        xfer(8'h05, d);
        xfer(8'h00, s);
        cs_hi();
    endtask

    task automatic read1(input logic [23:0] a, output logic [7:0] rd);
        logic [7:0] d;
        cs_lo();
        xfer(8'h03, d);
        send_addr(a);
        xfer(8'h00, rd);
        cs_hi();
    endtask

    task automatic pp1(input logic [23:0] a, input logic [7:0] data);
        logic [7:0] d;
        cs_lo();
        xfer(8'h02, d);
        send_addr(a);
        xfer(data, d);
        cs_hi();
    endtask

    task automatic wait_wip_idle(input int limit);
        int n = 0;
        while (spi.wip !== 1'b0 && n < limit) begin
            clk_wait(1);
            n++;
        end
        if (spi.wip !== 1'b0) begin
            n_vec++;
            n_err++;
            $display("FAIL wip_timeout: got wip=%0b after %0d cycles expected 0", spi.wip, n);
        end
        clk_wait(2);
    endtask

    vec_t vecs [17];

    initial begin
        logic [7:0] rd;
        logic [7:0] d;

        vecs[0]  = '{"read_pwrup_10", K_READ, 8'h03, 24'h000010, 8'h00, 8'hFF, 1'b0};
        vecs[1]  = '{"wren",          K_CMD,  8'h06, 24'h0,      8'h00, 8'h00, 1'b1};
        vecs[2]  = '{"rdsr_wel",      K_RDSR, 8'h05, 24'h0,      8'h00, 8'h02, 1'b1};
        vecs[3]  = '{"wrdi",          K_CMD,  8'h04, 24'h0,      8'h00, 8'h00, 1'b0};
        vecs[4]  = '{"rdsr_clear",    K_RDSR, 8'h05, 24'h0,      8'h00, 8'h00, 1'b0};
        vecs[5]  = '{"wren2",         K_CMD,  8'h06, 24'h0,      8'h00, 8'h00, 1'b1};
        vecs[6]  = '{"pp_10_f0",      K_PP,   8'h02, 24'h000010, 8'hF0, 8'h00, 1'b0};
        vecs[7]  = '{"read_10",       K_READ, 8'h03, 24'h000010, 8'h00, 8'hF0, 1'b0};
        vecs[8]  = '{"wren3",         K_CMD,  8'h06, 24'h0,      8'h00, 8'h00, 1'b1};
        vecs[9]  = '{"unknown_9f",    K_CMD,  8'h9F, 24'h0,      8'h00, 8'h00, 1'b1};
        vecs[10] = '{"pp_20_5a",      K_PP,   8'h02, 24'h123420, 8'h5A, 8'h00, 1'b0};
        vecs[11] = '{"read_20",       K_READ, 8'h03, 24'hABCD20, 8'h00, 8'h5A, 1'b0};
        vecs[12] = '{"wren4",         K_CMD,  8'h06, 24'h0,      8'h00, 8'h00, 1'b1};
        vecs[13] = '{"rdsr_wel2",     K_RDSR, 8'h05, 24'h0,      8'h00, 8'h02, 1'b1};
        vecs[14] = '{"wrdi2",         K_CMD,  8'h04, 24'h0,      8'h00, 8'h00, 1'b0};
        vecs[15] = '{"pp_30_nowel",   K_PP,   8'h02, 24'h000030, 8'h00, 8'h00, 1'b0};
        vecs[16] = '{"read_30",       K_READ, 8'h03, 24'h000030, 8'h00, 8'hFF, 1'b0};

        spi.sck  = 1'b0;
        spi.cs   = 1'b1;
        spi.mosi = 1'b0;
        rst_n    = 1'b0;
        clk_wait(4);
        rst_n = 1'b1;
        clk_wait(4);

        chk("reset_wel",   spi.wel, 1'b0);
        chk("reset_wip",   spi.wip, 1'b0);
        chk("reset_state", spi.state_out, 4'd0);
        chk("reset_miso",  spi.miso, 1'b0);

        // power-up read of two bytes
        cs_lo();
        xfer(8'h03, d);
        send_addr(24'h000010);
        chk("t1_state_read", spi.state_out, 4'd3);
        xfer(8'h00, rd);
        chk("t1_byte0", rd, 8'hFF);
        xfer(8'h00, rd);
        chk("t1_byte1", rd, 8'hFF);
        chk("t1_state_read2", spi.state_out, 4'd3);
        cs_hi();
        chk("t1_wel", spi.wel, 1'b0);
        chk("t1_idle", spi.state_out, 4'd0);

        // page program without WREN is ignored
        cs_lo();
        xfer(8'h02, d);
        send_addr(24'h000005);
        chk("t2_state_ignore", spi.state_out, 4'd6);
        xfer(8'hA5, d);
        cs_hi();
        chk("t2_no_wip", spi.wip, 1'b0);
        read1(24'h000005, rd);
        chk("t2_read_05", rd, 8'hFF);

        for (int i = 0; i < 17; i++) begin
            rd = 8'h00;
            case (vecs[i].kind)
                K_CMD:  cmd(vecs[i].op);
                K_RDSR: rdsr(rd);
                K_READ: read1(vecs[i].addr, rd);
                default: pp1(vecs[i].addr, vecs[i].data);
            endcase
            wait_wip_idle(4 * ERASE_CYC);
            if (vecs[i].kind == K_RDSR || vecs[i].kind == K_READ)
                chk({vecs[i].name, "_data"}, rd, vecs[i].exp_rd);
            chk({vecs[i].name, "_wel"}, spi.wel, vecs[i].exp_wel);
        end

        // page program with page wrap, status while busy
        cmd(8'h06);
        rdsr(rd);
        chk("t3_rdsr_wel", rd, 8'h02);
        cs_lo();
        xfer(8'h02, d);
        send_addr(24'h0000FE);
        xfer(8'h12, d);
        xfer(8'h34, d);
        xfer(8'h56, d);
        cs_hi();
        rdsr(rd);
        chk("t3_rdsr_busy", rd, 8'h01);
        wait_wip_idle(4 * ERASE_CYC);
        chk("t3_wip_len", wip_last, PROG_CYC);
        rdsr(rd);
        chk("t3_rdsr_done", rd, 8'h00);
        cs_lo();
        xfer(8'h03, d);
        send_addr(24'h0000FE);
        xfer(8'h00, rd);
        chk("t3_read_fe", rd, 8'h12);
        xfer(8'h00, rd);
        chk("t3_read_ff", rd, 8'h34);
        xfer(8'h00, rd);
        chk("t3_read_00", rd, 8'h56);
        cs_hi();

        // AND semantics with a trailing partial byte
        cmd(8'h06);
        cs_lo();
        xfer(8'h02, d);
        send_addr(24'h000010);
        xfer(8'h3C, d);
        xfer_bits(8'h00, 3, d);
        cs_hi();
        chk("t4_wip_set", spi.wip, 1'b1);
        chk("t4_wel_clr", spi.wel, 1'b0);
        wait_wip_idle(4 * ERASE_CYC);
        read1(24'h000010, rd);
        chk("t4_read_10", rd, 8'h30);
        read1(24'h000011, rd);
        chk("t4_read_11", rd, 8'hFF);

        // chip erase, READ rejected while busy
        cmd(8'h06);
        cmd(8'hC7);
        chk("t5_wip_set", spi.wip, 1'b1);
        chk("t5_wel_clr", spi.wel, 1'b0);
        cs_lo();
        xfer(8'h03, d);
        send_addr(24'h000000);
        chk("t5_state_ignore", spi.state_out, 4'd6);
        xfer(8'h00, rd);
        chk("t5_read_busy", rd, 8'h00);
        cs_hi();
        chk("t5_still_busy", spi.wip, 1'b1);
        wait_wip_idle(4 * ERASE_CYC);
        chk("t5_wip_len", wip_last, ERASE_CYC);
        cs_lo();
        xfer(8'h03, d);
        send_addr(24'h000000);
        xfer(8'h00, rd);
        chk("t5_read_00", rd, 8'hFF);
        xfer(8'h00, rd);
        chk("t5_read_01", rd, 8'hFF);
        xfer(8'h00, rd);
        chk("t5_read_02", rd, 8'hFF);
        cs_hi();

        // aborted opcode and aborted address
        cs_lo();
        xfer_bits(8'h06, 5, d);
        cs_hi();
        chk("t6_abort_opcode_wel", spi.wel, 1'b0);
        cmd(8'h06);
        cs_lo();
        xfer(8'h02, d);
        xfer(8'h00, d);
        xfer(8'h00, d);
        cs_hi();
        chk("t6_abort_addr_wel", spi.wel, 1'b1);
        chk("t6_abort_addr_wip", spi.wip, 1'b0);

        // reset in the middle of an erase sweep
        pp1(24'h000000, 8'h00);
        wait_wip_idle(4 * ERASE_CYC);
        cmd(8'h06);
        pp1(24'h0000F0, 8'h00);
        wait_wip_idle(4 * ERASE_CYC);
        cmd(8'h06);
        cmd(8'hC7);
        clk_wait(40);
        rst_n = 1'b0;
        clk_wait(1);
        rst_n = 1'b1;
        clk_wait(2);
        chk("t6_rst_wip",   spi.wip, 1'b0);
        chk("t6_rst_wel",   spi.wel, 1'b0);
        chk("t6_rst_state", spi.state_out, 4'd0);
        read1(24'h000000, rd);
        chk("t6_swept_00", rd, 8'hFF);
        read1(24'h0000F0, rd);
        chk("t6_kept_f0", rd, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
